// File: rtl/pal_rd_responder.sv
// Palette read responder: DEPTH-entry register table with a write port, in-order
// valid/ready lookups buffered in an RS_DEPTH FIFO. Optional macro: PAL_RD_BYPASS_EN.
module pal_rd_responder #(
  parameter int W_DATA   = 32,
  parameter int W_ADDR   = 16,
  parameter int DEPTH    = 16,
  parameter int RS_DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        resetn,
  input  logic                        wr_en,
  input  logic [W_ADDR-1:0]           wr_addr,
  input  logic [W_DATA-1:0]           wr_data,
  input  logic                        rq_valid,
  output logic                        rq_ready,
  input  logic [W_ADDR-1:0]           rq_addr,
  output logic                        rs_valid,
  input  logic                        rs_ready,
  output logic [W_DATA-1:0]           rs_data,
  output logic                        rs_err,
  output logic [$clog2(RS_DEPTH):0]   o_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int LW = $clog2(RS_DEPTH) + 1;

  logic [W_DATA-1:0] tbl     [DEPTH];
  logic [W_DATA-1:0] fq_data [RS_DEPTH];
  logic              fq_err  [RS_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              wr_hit, rq_hit, push, pop;
  logic [W_DATA-1:0] rd_word;
  logic              rd_err;

  assign wr_hit   = wr_en && (wr_addr < W_ADDR'(DEPTH));
  assign rq_hit   = rq_addr < W_ADDR'(DEPTH);
  assign rs_valid = (level != '0);
  assign pop      = rs_valid && rs_ready;
  assign rq_ready = (level < LW'(RS_DEPTH)) || pop;
  assign push     = rq_valid && rq_ready;
  assign rs_data  = fq_data[rd_ptr];
  assign rs_err   = fq_err[rd_ptr];
  assign o_level  = level;

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_hit) begin
      tbl[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b1;
    if (rq_hit) begin
      rd_err  = 1'b0;
      rd_word = tbl[rq_addr[AW-1:0]];
`ifdef PAL_RD_BYPASS_EN
      // same-edge write to the looked-up index is forwarded instead of the stale entry
      if (wr_hit && (wr_addr == rq_addr)) rd_word = wr_data;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        fq_data[i] <= '0;
        fq_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fq_data[wr_ptr] <= rd_word;
        fq_err[wr_ptr]  <= rd_err;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_pal_rd_responder.sv
// Scoreboard bench for pal_rd_responder: driver queues expected {err,data} on each
// accepted request, a negedge monitor compares on every response handshake.
module tb_pal_rd_responder;

  localparam int W_DATA = 32;
  localparam int W_ADDR = 16;

  logic              i_clk = 1'b0;
  logic              resetn;
  logic              wr_en;
  logic [W_ADDR-1:0] wr_addr;
  logic [W_DATA-1:0] wr_data;
  logic              rq_valid;
  logic              rq_ready;
  logic [W_ADDR-1:0] rq_addr;
  logic              rs_valid;
  logic              rs_ready;
  logic [W_DATA-1:0] rs_data;
  logic              rs_err;
  logic [1:0]        o_level;

  int errors = 0;
  int checks = 0;
  logic [W_DATA:0] sb[$];
  logic [W_DATA-1:0] model [16];

  pal_rd_responder #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .DEPTH(16), .RS_DEPTH(2)) dut (
    .i_clk(i_clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data), .rs_err(rs_err),
    .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: response handshake visible at negedge completes at the next posedge.
  always @(negedge i_clk) begin
    if (resetn === 1'b1 && rs_valid && rs_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_response", {31'd0, rs_err, rs_data}, 64'd0);
      end else begin
        logic [W_DATA:0] e;
        e = sb.pop_front();
        chk("response", {31'd0, rs_err, rs_data}, {31'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [W_DATA-1:0] d);
    wr_en = 1'b1; wr_addr = W_ADDR'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    if (a < 16) model[a] = d;
  endtask

  task automatic req(input int a, input logic [W_DATA-1:0] exp_d, input logic exp_e);
    logic acc;
    int n;
    rq_valid = 1'b1; rq_addr = W_ADDR'(a); n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge i_clk);
      acc = rq_ready;
      if (acc) sb.push_back({exp_e, exp_d});
      step();
      n++;
    end
    rq_valid = 1'b0;
    if (!acc) chk("req_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rs_valid"}, 64'(rs_valid), 64'd0);
    chk({tag, "_o_level"},  64'(o_level),  64'd0);
    chk({tag, "_rq_ready"}, 64'(rq_ready), 64'd1);
    chk({tag, "_rs_data"},  64'(rs_data),  64'd0);
    chk({tag, "_rs_err"},   64'(rs_err),   64'd0);
  endtask

  initial begin
    logic [W_DATA-1:0] coll_exp;
    int n;
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rq_valid = 1'b0; rq_addr = '0; rs_ready = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge i_clk);
    #1 resetn = 1'b1;
    step();

    // basic read with single-cycle latency
    wr(3, 32'hDEADBEEF);
    rs_ready = 1'b1;
    req(3, 32'hDEADBEEF, 1'b0);
    chk("latency_rs_valid", 64'(rs_valid), 64'd1);
    step();
    chk("drain_o_level", 64'(o_level), 64'd0);

    // out-of-range read and out-of-range write (20 would alias entry 4 if truncated)
    req(16, 32'h0, 1'b1);
    req(16'hFFFF, 32'h0, 1'b1);
    wr(4, 32'h0000_0044);
    wr(20, 32'h0000_0BAD);
    wr(5, 32'h0000_0011);
    wr(1, 32'h0000_00A1);
    wr(2, 32'h0000_00A2);
    wr(6, 32'h0000_00A6);
    for (int i = 0; i < 16; i++) req(i, model[i], 1'b0);

    // backpressure: two fill the FIFO, third waits, then push+pop together
    step();
    rs_ready = 1'b0;
    req(1, 32'h0000_00A1, 1'b0);
    req(2, 32'h0000_00A2, 1'b0);
    chk("full_o_level", 64'(o_level), 64'd2);
    chk("full_rq_ready", 64'(rq_ready), 64'd0);
    rq_valid = 1'b1; rq_addr = 16'd6;
    step(); step();
    chk("stall_rq_ready", 64'(rq_ready), 64'd0);
    chk("stall_o_level", 64'(o_level), 64'd2);
    rs_ready = 1'b1;
    req(6, 32'h0000_00A6, 1'b0);
    chk("pushpop_o_level", 64'(o_level), 64'd2);
    repeat (3) step();
    chk("drained_o_level", 64'(o_level), 64'd0);

    // same-edge write/read collision on entry 5
`ifdef PAL_RD_BYPASS_EN
    coll_exp = 32'h0000_0055;
`else
    coll_exp = 32'h0000_0011;
`endif
    wr_en = 1'b1; wr_addr = 16'd5; wr_data = 32'h0000_0055;
    req(5, coll_exp, 1'b0);
    wr_en = 1'b0; model[5] = 32'h0000_0055;
    req(5, 32'h0000_0055, 1'b0);
    repeat (3) step();

    // reset while the FIFO holds responses
    rs_ready = 1'b0;
    req(1, 32'h0000_00A1, 1'b0);
    req(2, 32'h0000_00A2, 1'b0);
    chk("prereset_o_level", 64'(o_level), 64'd2);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(posedge i_clk);
    #1 resetn = 1'b1;
    rs_ready = 1'b1;
    req(3, 32'h0, 1'b0);
    req(5, 32'h0, 1'b0);
    req(6, 32'h0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin step(); n++; end
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
